// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and constants for the two-requester data memory arbiter.
package data_memory_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arbState_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DMA = 1'b1;

   localparam int MEM_BYTES_DEFAULT = 128;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick; the caller owns the last-grant register.
module rr_pick2
   import data_memory_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant
);

   always_comb begin
      grant = REQ_CPU;
      if (req == 2'b10) begin
         grant = REQ_DMA;
      end else if (req == 2'b11) begin
         grant = ~last;
      end
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter for a single-port data memory, one access per three cycles.
// Optional address bounds checking: define DATA_MEMORY_ARBITER_BOUNDS_CHECK_EN.
//
// state  | meaning
// IDLE   | sample Req0/Req1, latch winner's payload
// ACCESS | drive memory strobes, Gnt to winner
// DONE   | Done (and Err) pulse to winner
module data_memory_arbiter
   import data_memory_arbiter_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Req0,
   input  logic              Req1,
   input  logic              We0,
   input  logic              We1,
   input  logic [ADDR_W-1:0] Addr0,
   input  logic [ADDR_W-1:0] Addr1,
   input  logic [DATA_W-1:0] WData0,
   input  logic [DATA_W-1:0] WData1,
   output logic              Gnt0,
   output logic              Gnt1,
   output logic              Done0,
   output logic              Done1,
   output logic [DATA_W-1:0] RData0,
   output logic [DATA_W-1:0] RData1,
   output logic              Err0,
   output logic              Err1,
   output logic [ADDR_W-1:0] MemAddress,
   output logic [DATA_W-1:0] MemWriteData,
   output logic              MemWrite,
   output logic              MemRead,
   input  logic [DATA_W-1:0] MemReadData
);

   arbState_t         state;
   arbState_t         stateNext;
   logic              lastGnt;
   logic              curId;
   logic              wrFlag;
   logic              badFlag;
   logic              pick;
   logic              badNext;
   logic              anyReq;
   logic              inAccess;
   logic              inDone;
   logic              memOk;
   logic [ADDR_W-1:0] pickAddr;
   logic [DATA_W-1:0] rdCapture;

   assign anyReq = Req0 | Req1;

   rr_pick2 uPick (
      .req   ({Req1, Req0}),
      .last  (lastGnt),
      .grant (pick)
   );

   assign pickAddr = (pick == REQ_DMA) ? Addr1 : Addr0;

`ifdef DATA_MEMORY_ARBITER_BOUNDS_CHECK_EN
   localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 2);
   assign badNext = pickAddr[0] | (pickAddr > MAX_ADDR);
`else
   assign badNext = 1'b0;
`endif

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (anyReq) stateNext = ACCESS;
         ACCESS:  stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Strobes are gated by Reset so a write caught by reset never commits.
   always_comb begin
      inAccess = (state == ACCESS);
      inDone   = (state == DONE) && !Reset;
      memOk    = inAccess && !badFlag && !Reset;
      Gnt0     = inAccess && (curId == REQ_CPU);
      Gnt1     = inAccess && (curId == REQ_DMA);
      MemWrite = memOk && wrFlag;
      MemRead  = memOk && !wrFlag;
      Done0    = inDone && (curId == REQ_CPU);
      Done1    = inDone && (curId == REQ_DMA);
      Err0     = Done0 && badFlag;
      Err1     = Done1 && badFlag;
   end

   assign rdCapture = badFlag ? '0 : MemReadData;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state        <= IDLE;
         lastGnt      <= REQ_DMA;
         curId        <= REQ_CPU;
         wrFlag       <= 1'b0;
         badFlag      <= 1'b0;
         MemAddress   <= '0;
         MemWriteData <= '0;
         RData0       <= '0;
         RData1       <= '0;
      end else begin
         state <= stateNext;
         if (state == IDLE && anyReq) begin
            curId        <= pick;
            lastGnt      <= pick;
            wrFlag       <= (pick == REQ_DMA) ? We1 : We0;
            badFlag      <= badNext;
            MemAddress   <= pickAddr;
            MemWriteData <= (pick == REQ_DMA) ? WData1 : WData0;
         end
         // A rejected access of either kind returns zero read data.
         if (inAccess && (badFlag || !wrFlag)) begin
            if (curId == REQ_CPU) RData0 <= rdCapture;
            else                  RData1 <= rdCapture;
         end
      end
   end

endmodule
